// File: rtl/scoreboard_reg_file_if.sv
// Register-file and scoreboard signal bundle: source reads, destination claim, writeback.
interface scoreboard_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              stall_flag;
    logic [ADDR_W-1:0] inst_read_reg_addr1;
    logic [ADDR_W-1:0] inst_read_reg_addr2;
    logic [DATA_W-1:0] reg_file_rd_data1;
    logic [DATA_W-1:0] reg_file_rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dst;
    logic              issue_ready;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic [ADDR_W:0]   busy_count;

    modport master (
        output stall_flag, inst_read_reg_addr1, inst_read_reg_addr2,
        output issue_valid, issue_dst, reg_wr, reg_wr_addr, reg_wr_data,
        input  reg_file_rd_data1, reg_file_rd_data2, rd_busy1, rd_busy2,
        input  issue_ready, busy_count
    );

    modport slave (
        input  stall_flag, inst_read_reg_addr1, inst_read_reg_addr2,
        input  issue_valid, issue_dst, reg_wr, reg_wr_addr, reg_wr_data,
        output reg_file_rd_data1, reg_file_rd_data2, rd_busy1, rd_busy2,
        output issue_ready, busy_count
    );
endinterface

// File: rtl/scoreboard_reg_file.sv
// Register file with per-register pending bits for destination claim / writeback tracking.
// Latency: reads registered, 1 cycle, with same-edge writeback bypass and post-edge busy.
// Backpressure: issue_ready drops while stalled or while the destination is still pending.
module scoreboard_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic                 clk,
    input logic                 reset,
    scoreboard_reg_file_if.slave sb
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_nxt;
    logic [CNT_W-1:0]  busy_count_q;
    logic [CNT_W-1:0]  busy_count_nxt;

    logic              wr_en;
    logic              wr_hits_dst;
    logic              issue_fire;
    logic              set_en;
    logic [DATA_W-1:0] rd_data1_nxt;
    logic [DATA_W-1:0] rd_data2_nxt;
    logic              rd_busy1_q;
    logic              rd_busy2_q;
    logic [DATA_W-1:0] rd_data1_q;
    logic [DATA_W-1:0] rd_data2_q;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Source value as it will be after this edge: writeback data is forwarded.
    function automatic logic [DATA_W-1:0] src_data(input logic [ADDR_W-1:0] a);
        if (is_zero_reg(a))
            return '0;
        else if (wr_en && (sb.reg_wr_addr == a))
            return sb.reg_wr_data;
        else
            return regs[a];
    endfunction

    always_comb begin
        wr_en       = sb.reg_wr && !is_zero_reg(sb.reg_wr_addr);
        wr_hits_dst = sb.reg_wr && (sb.reg_wr_addr == sb.issue_dst);
        // A writeback freeing the destination this cycle lets a new claim through.
        sb.issue_ready = !sb.stall_flag && (!pending[sb.issue_dst] || wr_hits_dst);
        issue_fire  = sb.issue_valid && sb.issue_ready;
        set_en      = issue_fire && !is_zero_reg(sb.issue_dst);
    end

    // Clear before set so a same-cycle claim of a written register stays pending.
    always_comb begin
        pending_nxt = pending;
        if (wr_en)
            pending_nxt[sb.reg_wr_addr] = 1'b0;
        if (set_en)
            pending_nxt[sb.issue_dst] = 1'b1;
    end

    always_comb begin
        busy_count_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            busy_count_nxt = busy_count_nxt + CNT_W'(pending_nxt[i]);
    end

    always_comb begin
        rd_data1_nxt = src_data(sb.inst_read_reg_addr1);
        rd_data2_nxt = src_data(sb.inst_read_reg_addr2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            pending      <= '0;
            busy_count_q <= '0;
            rd_data1_q   <= '0;
            rd_data2_q   <= '0;
            rd_busy1_q   <= 1'b0;
            rd_busy2_q   <= 1'b0;
        end else begin
            if (wr_en)
                regs[sb.reg_wr_addr] <= sb.reg_wr_data;
            pending      <= pending_nxt;
            busy_count_q <= busy_count_nxt;
            if (!sb.stall_flag) begin
                rd_data1_q <= rd_data1_nxt;
                rd_data2_q <= rd_data2_nxt;
                rd_busy1_q <= pending_nxt[sb.inst_read_reg_addr1];
                rd_busy2_q <= pending_nxt[sb.inst_read_reg_addr2];
            end
        end
    end

    assign sb.reg_file_rd_data1 = rd_data1_q;
    assign sb.reg_file_rd_data2 = rd_data2_q;
    assign sb.rd_busy1          = rd_busy1_q;
    assign sb.rd_busy2          = rd_busy2_q;
    assign sb.busy_count        = busy_count_q;

    localparam int MAX_CNT = (ZERO_REG != 0) ? NREGS - 1 : NREGS;

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        int'(busy_count_q) <= MAX_CNT);

endmodule

// File: tb/tb_scoreboard_reg_file.sv
module tb_scoreboard_reg_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    scoreboard_reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sb_if ();

    scoreboard_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    typedef struct {
        logic              rst;
        logic              stall;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic              iv;
        logic [ADDR_W-1:0] idst;
        logic              wr;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              chk_rdy;
        logic              e_rdy;
        logic [DATA_W-1:0] e_rd1;
        logic [DATA_W-1:0] e_rd2;
        logic              e_b1;
        logic              e_b2;
        logic [ADDR_W:0]   e_cnt;
    } vec_t;

    vec_t tab_a [16];
    vec_t tab_b [3];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, got, exp);
    endtask

    task automatic drive(input vec_t v);
        reset                     = v.rst;
        sb_if.stall_flag          = v.stall;
        sb_if.inst_read_reg_addr1 = v.a1;
        sb_if.inst_read_reg_addr2 = v.a2;
        sb_if.issue_valid         = v.iv;
        sb_if.issue_dst           = v.idst;
        sb_if.reg_wr              = v.wr;
        sb_if.reg_wr_addr         = v.waddr;
        sb_if.reg_wr_data         = v.wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        if (v.chk_rdy)
            check("issue_ready", idx, 64'(sb_if.issue_ready), 64'(v.e_rdy));
        @(posedge clk);
        #1;
        check("rd_data1", idx, 64'(sb_if.reg_file_rd_data1), 64'(v.e_rd1));
        check("rd_data2", idx, 64'(sb_if.reg_file_rd_data2), 64'(v.e_rd2));
        check("rd_busy1", idx, 64'(sb_if.rd_busy1), 64'(v.e_b1));
        check("rd_busy2", idx, 64'(sb_if.rd_busy2), 64'(v.e_b2));
        check("busy_count", idx, 64'(sb_if.busy_count), 64'(v.e_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        //            rst stall a1 a2 iv dst wr wa wdata   chk rdy rd1     rd2     b1 b2 cnt
        tab_a[0]  = '{1, 0,    0, 0, 0, 0,  0, 0, 0,      0,  0,  0,      0,      0, 0, 0};
        tab_a[1]  = '{0, 0,    5, 0, 0, 0,  1, 5, 'h55,   1,  1,  'h55,   0,      0, 0, 0};
        tab_a[2]  = '{0, 0,    5, 0, 0, 0,  0, 0, 0,      1,  1,  'h55,   0,      0, 0, 0};
        tab_a[3]  = '{0, 0,    7, 5, 1, 7,  0, 0, 0,      1,  1,  0,      'h55,   1, 0, 1};
        tab_a[4]  = '{0, 0,    7, 5, 1, 7,  0, 0, 0,      1,  0,  0,      'h55,   1, 0, 1};
        tab_a[5]  = '{0, 0,    7, 7, 0, 7,  1, 7, 'h77,   1,  1,  'h77,   'h77,   0, 0, 0};
        tab_a[6]  = '{0, 0,    3, 0, 1, 3,  0, 0, 0,      1,  1,  0,      0,      1, 0, 1};
        tab_a[7]  = '{0, 0,    3, 0, 1, 3,  1, 3, 'hA,    1,  1,  'hA,    0,      1, 0, 1};
        tab_a[8]  = '{0, 0,    3, 0, 0, 3,  1, 3, 'hB,    1,  1,  'hB,    0,      0, 0, 0};
        tab_a[9]  = '{0, 0,    9, 0, 0, 0,  1, 9, 'h9,    1,  1,  'h9,    0,      0, 0, 0};
        tab_a[10] = '{0, 0,    5, 9, 0, 0,  0, 0, 0,      1,  1,  'h55,   'h9,    0, 0, 0};
        tab_a[11] = '{0, 1,    9, 3, 1, 4,  1, 5, 'h99,   1,  0,  'h55,   'h9,    0, 0, 0};
        tab_a[12] = '{0, 1,    3, 3, 0, 4,  0, 0, 0,      1,  0,  'h55,   'h9,    0, 0, 0};
        tab_a[13] = '{0, 0,    5, 3, 0, 0,  0, 0, 0,      1,  1,  'h99,   'hB,    0, 0, 0};
        tab_a[14] = '{0, 0,    0, 0, 1, 0,  1, 0, 'hFF,   1,  1,  0,      0,      0, 0, 0};
        tab_a[15] = '{0, 0,    0, 5, 0, 0,  0, 0, 0,      1,  1,  0,      'h99,   0, 0, 0};
        // Reset while every register is claimed, with a concurrent claim, write and stall.
        tab_b[0]  = '{1, 1,    1, 2, 1, 1,  1, 1, 'h11,   0,  0,  0,      0,      0, 0, 0};
        tab_b[1]  = '{0, 0,    1, 5, 0, 1,  0, 0, 0,      1,  1,  0,      0,      0, 0, 0};
        tab_b[2]  = '{0, 0,    2, 3, 1, 2,  0, 0, 0,      1,  1,  0,      0,      1, 0, 1};

        v = tab_a[0];
        drive(v);

        for (int i = 0; i < 16; i++)
            run_vec(tab_a[i], i);

        // Claim r1..r31; each claim must be accepted.
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            v = tab_a[2];
            v.a1 = ADDR_W'(r);
            v.a2 = '0;
            v.iv = 1'b1;
            v.idst = ADDR_W'(r);
            drive(v);
            #1;
            check("claim_ready", 100 + r, 64'(sb_if.issue_ready), 64'(1));
            @(posedge clk);
        end
        #1;
        check("claim_all_count", 200, 64'(sb_if.busy_count), 64'(31));
        check("claim_all_busy1", 200, 64'(sb_if.rd_busy1), 64'(1));

        @(negedge clk);
        sb_if.issue_dst = 5'd5;
        #1;
        check("reclaim_blocked", 201, 64'(sb_if.issue_ready), 64'(0));
        sb_if.issue_dst = 5'd0;
        sb_if.inst_read_reg_addr1 = 5'd0;
        #1;
        check("r0_claim_ready", 202, 64'(sb_if.issue_ready), 64'(1));
        @(posedge clk);
        #1;
        check("r0_claim_count", 202, 64'(sb_if.busy_count), 64'(31));
        check("r0_claim_busy", 202, 64'(sb_if.rd_busy1), 64'(0));

        for (int i = 0; i < 3; i++)
            run_vec(tab_b[i], 300 + i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/scoreboard_reg_file.md
SCOREBOARD_REG_FILE -- requirements
Module: scoreboard_reg_file

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning the register data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning the register address width; register count NREGS = 2**ADDR_W.
REQ-003 The module SHALL have parameter ZERO_REG, default 1, meaning that when 1, register 0 is hardwired to zero.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The module SHALL have port stall_flag, input, 1 bit; when 1, it freezes the read outputs and blocks issue.
REQ-007 The module SHALL have ports inst_read_reg_addr1 and inst_read_reg_addr2, input, ADDR_W bits each, the source register addresses.
REQ-008 The module SHALL have ports reg_file_rd_data1 and reg_file_rd_data2, output, DATA_W bits each, registered read data.
REQ-009 The module SHALL have ports rd_busy1 and rd_busy2, output, 1 bit each, registered flags marking the source as awaiting writeback.
REQ-010 The module SHALL have ports issue_valid (input, 1 bit), issue_dst (input, ADDR_W bits) and issue_ready (output, 1 bit), the destination-claim handshake.
REQ-011 The module SHALL have ports reg_wr (input, 1 bit), reg_wr_addr (input, ADDR_W bits) and reg_wr_data (input, DATA_W bits), the writeback port.
REQ-012 The module SHALL have port busy_count, output, ADDR_W+1 bits, the registered number of pending registers.

Function
REQ-013 Storage SHALL be NREGS x DATA_W registers plus one pending bit per register.
REQ-014 Writeback: at a clk edge with reg_wr=1, regs[reg_wr_addr] SHALL take reg_wr_data and pending[reg_wr_addr] SHALL clear; stall_flag SHALL NOT block writeback.
REQ-015 Issue fire SHALL be issue_valid & issue_ready; on fire, pending[issue_dst] SHALL set at the edge.
REQ-016 issue_ready SHALL be combinational: !stall_flag & (!pending[issue_dst] | (reg_wr & reg_wr_addr==issue_dst)).
REQ-017 If a writeback and an issue fire target the same register in one cycle, the data SHALL be written and pending SHALL end set (set wins).
REQ-018 Read: at an edge with stall_flag=0, reg_file_rd_dataN SHALL load the source register value, bypassed to reg_wr_data when reg_wr=1 and reg_wr_addr equals the source address.
REQ-019 Read: at that same edge, rd_busyN SHALL load the post-edge pending bit of the source register, i.e. including same-cycle clear and set.
REQ-020 When stall_flag=1, reg_file_rd_dataN and rd_busyN SHALL hold their values; the read latency is 1 cycle.
REQ-021 When ZERO_REG=1: writes to register 0 SHALL be ignored, reads of register 0 SHALL return 0 with busy 0, and issue to register 0 SHALL be always ready and SHALL NOT set pending.
REQ-022 busy_count SHALL equal the population count of the pending bits after each edge; +1 on an issue-only update, -1 on a clear-only update, and unchanged when both occur or neither does.
REQ-023 busy_count SHALL NOT wrap; its maximum is NREGS, or NREGS-1 when ZERO_REG=1.
REQ-024 A writeback to a register that is not pending SHALL write the data and leave pending at 0.

Reset
REQ-025 At an edge with reset=1: all registers SHALL become 0, all pending bits 0, reg_file_rd_data1/2 0, rd_busy1/2 0, and busy_count 0.
REQ-026 Reset SHALL dominate the same-cycle reg_wr, issue and stall_flag, and SHALL abort in-flight claims mid-operation.
REQ-027 issue_ready SHALL NOT depend on reset combinationally; after reset, it SHALL follow REQ-016 with all pending bits 0.

Verification
REQ-028 Reset, then reg_wr to r5 with 0x55, then read r5/r0 with stall_flag=0 -> next cycle rd_data1=0x55, rd_data2=0, both busy 0.
REQ-029 Issue r7, then read r7 -> rd_busy1=1, busy_count=1, and issue to r7 gives issue_ready=0; writeback r7=0x77 -> the same-edge read returns 0x77 with busy 0 and busy_count 0.
REQ-030 Pending r3, with issue r3 and writeback r3=0xA in the same cycle -> issue_ready=1, data 0xA, pending stays 1, and busy_count unchanged.
REQ-031 Read r5=0x55 latched, then stall_flag=1 while writing r5=0x99 and changing addresses -> outputs hold 0x55; on deassert the next edge gives 0x99.
REQ-032 Issue r0 and write r0=0xFF with ZERO_REG=1 -> r0 reads 0 with busy 0 and busy_count 0; claim all other registers -> busy_count=31.
REQ-033 Claim r1 and r2, then assert reset with a simultaneous issue and reg_wr -> all outputs 0, busy_count 0, and no register written.
